matrix_feeder: RTL and testbench
================================

Name: matrix_feeder

Overview:
Host-side driver for the matrixMultiplier st/data_in/done/dataout interface. It holds operand matrices A and B loaded by a host, issues the start strobe and streams operand bytes. It then captures the result bytes returned under done into a result buffer the host can read. It sits between host/control logic and matrixMultiplier, and is the producer/consumer at the opposite end of that interface.

Parameters:
N, 3, matrix dimension (N x N operands and result)
DW, 8, element width in bits; matches data_in/dataout
TIMEOUT, 1023, maximum WAIT cycles for done before an error is flagged

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
ld_we  in  1  host operand write enable
ld_addr  in  clog2(2*N*N)  operand index: 0..N*N-1 = A row-major; N*N..2*N*N-1 = B row-major
ld_data  in  DW  operand byte
go  in  1  start request, sampled in IDLE only
busy  out  1  high from the cycle after go is accepted until return to IDLE
fin  out  1  one-cycle pulse when N*N results have been captured
err  out  1  sticky error (timeout or short result burst); cleared by the next accepted go or by rst
rd_addr  in  clog2(N*N)  result index, row-major
rd_data  out  DW  result byte, registered, 1-cycle latency
mm_st  out  1  start strobe to multiplier
mm_data_in  out  DW  operand stream to multiplier
mm_done  in  1  multiplier result-valid
mm_dataout  in  DW  multiplier result stream

Behaviour:
- Reset values: busy=0, fin=0, err=0, mm_st=0, mm_data_in=0, rd_data=0, state=IDLE, all counters=0. Operand and result storage is not reset.
- FSM states: IDLE, START, STREAM, WAIT, COLLECT, FINISH.
- IDLE: go=1 -> START and clears err. ld_we writes operand[ld_addr] only in IDLE. ld_we in any other state is ignored. go in any other state is ignored.
- START: mm_st=1 for exactly one cycle, then STREAM.
- STREAM: lasts exactly 2*N*N cycles. mm_data_in = operand[k] with k=0..2*N*N-1, one per cycle. operand[0] is presented the cycle after mm_st. After the last element, mm_data_in returns to 0 and the FSM enters WAIT.
- WAIT: a cycle counter counts up from 0. If mm_done=1, the FSM enters COLLECT and that same cycle's mm_dataout is captured as result[0]. If the counter reaches TIMEOUT, err=1 and the FSM returns to IDLE.
- COLLECT: captures result[j]=mm_dataout on each cycle with mm_done=1, j incrementing. After result[N*N-1] is captured, the FSM enters FINISH. If mm_done=0 before N*N captures, err=1 and the FSM returns to IDLE; results already captured are kept.
- FINISH: fin=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- rd_data <= result[rd_addr] on every clock. Reads are allowed in any state. Reading a slot while it is being written returns the old value.
- Out-of-range ld_addr or rd_addr: writes are dropped and reads return 0.
- rst in any state: the next cycle shows reset values, and any in-flight transfer is abandoned. The following go restarts from operand[0].
- Arithmetic: pure unsigned indices. Indices never wrap within a transfer.

Optional Feature:
FEEDER_CHECKSUM_EN. When defined, the block adds output port chk_sum [DW+clog2(N*N)-1:0]. chk_sum is cleared on accepted go and on rst, and accumulates every captured result byte as an unsigned value. It is valid while fin=1 and holds until the next go. When not defined, the port and accumulator do not exist and the behaviour is otherwise identical.

Decomposition:
- Package matrix_feeder_pkg: state enum, localparams OP_DEPTH=2*N*N, RES_DEPTH=N*N, and the address widths.
- One sub-module, feeder_ram: single-write, single-registered-read DW-wide register array, parameterised by depth. It is instantiated twice, for operands and for results.

Test Plan:
- Load A=1..9 and B=identity (1,0,0,0,1,0,0,0,1), then go. Required: mm_st high exactly 1 cycle, followed by mm_data_in = 1,2,...,9,1,0,0,0,1,0,0,0,1 on 18 consecutive cycles. The bench model then returns 9 bytes under mm_done. Required: fin pulses once, rd_addr=4 gives rd_data=5, and rd_addr=8 gives 9.
- Bench model never asserts mm_done. Required: err=1 and busy=0 exactly TIMEOUT=1023 cycles after entering WAIT, and fin never pulses.
- mm_done held for only 4 cycles. Required: err=1, return to IDLE, result[0..3] updated and result[4..8] unchanged.
- Assert rst while the 7th element is streaming. Required: the next cycle shows mm_st=0, mm_data_in=0, busy=0. A new go restarts the stream at operand[0]=1.
- ld_we with ld_addr=0, ld_data=0xFF, and go, both during STREAM. Required: both ignored; the next run streams the original operand[0]=1 and only one mm_st pulse occurs.
- With FEEDER_CHECKSUM_EN defined, run scenario 1. Required: chk_sum=45 while fin=1.

Source files
------------

// File: rtl/matrix_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matrix_feeder_pkg
// Purpose  : Shared FSM state type, default geometry and depth helpers for
//            the matrix_feeder block.
// Revision : 1.0 - initial release
// ============================================================================
package matrix_feeder_pkg;

    localparam int FEEDER_N       = 3;
    localparam int FEEDER_DW      = 8;
    localparam int FEEDER_TIMEOUT = 1023;

    localparam int OP_DEPTH  = 2 * FEEDER_N * FEEDER_N;
    localparam int RES_DEPTH = FEEDER_N * FEEDER_N;
    localparam int OP_AW     = $clog2(OP_DEPTH);
    localparam int RES_AW    = $clog2(RES_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_STREAM  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_COLLECT = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    function automatic int op_depth(input int n);
        return 2 * n * n;
    endfunction

    function automatic int res_depth(input int n);
        return n * n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : matrix_feeder_if
// Purpose  : Start/stream/done/result link between feeder and multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface matrix_feeder_if
    import matrix_feeder_pkg::*;
#(
    parameter int DW = FEEDER_DW
) ();

    logic          st;
    logic [DW-1:0] data_in;
    logic          done;
    logic [DW-1:0] dataout;

    modport master (
        output st,
        output data_in,
        input  done,
        input  dataout
    );

    modport slave (
        input  st,
        input  data_in,
        output done,
        output dataout
    );

endinterface
`default_nettype wire

// File: rtl/matrix_feeder_ram.sv
`default_nettype none
// ============================================================================
// Module   : feeder_ram
// Purpose  : Single-write, single registered-read register array. Writes
//            beyond DEPTH are dropped and such reads return zero.
// Revision : 1.0 - initial release
// ============================================================================
module feeder_ram
    import matrix_feeder_pkg::*;
#(
    parameter int DEPTH = RES_DEPTH,
    parameter int DW    = FEEDER_DW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [DW-1:0] wdata,
    input  wire logic [AW-1:0] raddr,
    output logic      [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;
    logic          w_ok;
    logic          r_ok;

    assign w_ok = (32'(waddr) < DEPTH);
    assign r_ok = (32'(raddr) < DEPTH);

    always_comb begin
        rdata_d = '0;
        if (r_ok) begin
            rdata_d = mem[raddr];
        end
    end

    // Storage itself is deliberately left unreset; only the read port is.
    always_ff @(posedge clk) begin
        if (we && w_ok) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/matrix_feeder.sv
`default_nettype none
// ============================================================================
// Module   : matrix_feeder
// Purpose  : Loads A/B operands, strobes and streams them to the multiplier,
//            then captures the N*N result bytes into a host-readable buffer.
//            Optional FEEDER_CHECKSUM_EN adds a running sum of results.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_feeder
    import matrix_feeder_pkg::*;
#(
    parameter int N       = FEEDER_N,
    parameter int DW      = FEEDER_DW,
    parameter int TIMEOUT = FEEDER_TIMEOUT
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         ld_we,
    input  wire logic [$clog2(2*N*N)-1:0]     ld_addr,
    input  wire logic [DW-1:0]                ld_data,
    input  wire logic                         go,
    output logic                              busy,
    output logic                              fin,
    output logic                              err,
    input  wire logic [$clog2(N*N)-1:0]       rd_addr,
    output logic      [DW-1:0]                rd_data,
    matrix_feeder_if.master                   mm
`ifdef FEEDER_CHECKSUM_EN
    ,
    output logic      [DW+$clog2(N*N)-1:0]    chk_sum
`endif
);

    localparam int OPD  = op_depth(N);
    localparam int RESD = res_depth(N);
    localparam int OPW  = $clog2(OPD);
    localparam int RESW = $clog2(RESD);
    localparam int WW   = $clog2(TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [OPW-1:0]  idx_q, idx_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [RESW-1:0] res_q, res_d;
    logic            err_q, err_d;
    logic [OPW-1:0]  op_raddr;
    logic [DW-1:0]   op_rdata;
    logic            op_we;
    logic            res_we;
    logic            go_acc;

    assign go_acc = (state_q == ST_IDLE) && go;
    assign op_we  = (state_q == ST_IDLE) && ld_we;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        res_d    = res_q;
        err_d    = err_q;
        op_raddr = '0;
        res_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_START;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    wait_d  = '0;
                    res_d   = '0;
                end
            end
            ST_START: begin
                // Prefetch element 0 so it appears the cycle after the strobe.
                op_raddr = '0;
                idx_d    = '0;
                state_d  = ST_STREAM;
            end
            ST_STREAM: begin
                op_raddr = idx_q + OPW'(1);
                if (idx_q == OPW'(OPD - 1)) begin
                    idx_d   = '0;
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end else begin
                    idx_d = idx_q + OPW'(1);
                end
            end
            ST_WAIT: begin
                if (mm.done) begin
                    res_we  = 1'b1;
                    res_d   = RESW'(1);
                    state_d = (RESD == 1) ? ST_FINISH : ST_COLLECT;
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    wait_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_COLLECT: begin
                if (mm.done) begin
                    res_we = 1'b1;
                    if (res_q == RESW'(RESD - 1)) begin
                        res_d   = '0;
                        state_d = ST_FINISH;
                    end else begin
                        res_d = res_q + RESW'(1);
                    end
                end else begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    feeder_ram #(
        .DEPTH (OPD),
        .DW    (DW),
        .AW    (OPW)
    ) u_op_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (op_we),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (op_raddr),
        .rdata (op_rdata)
    );

    feeder_ram #(
        .DEPTH (RESD),
        .DW    (DW),
        .AW    (RESW)
    ) u_res_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (res_we),
        .waddr (res_q),
        .wdata (mm.dataout),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign busy       = (state_q != ST_IDLE);
    assign fin        = (state_q == ST_FINISH);
    assign err        = err_q;
    assign mm.st      = (state_q == ST_START);
    assign mm.data_in = (state_q == ST_STREAM) ? op_rdata : '0;

`ifdef FEEDER_CHECKSUM_EN
    localparam int CSW = DW + RESW;

    logic [CSW-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (go_acc) begin
            sum_d = '0;
        end else if (res_we) begin
            sum_d = sum_q + CSW'(mm.dataout);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign chk_sum = sum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_feeder
// Purpose  : Self-checking bench for matrix_feeder with a behavioural
//            multiplier/host model and randomised operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_feeder;

    localparam int N       = 3;
    localparam int DW      = 8;
    localparam int TIMEOUT = 1023;
    localparam int NOP     = 2 * N * N;
    localparam int NRES    = N * N;

    logic           clk;
    logic           rst;
    logic           ld_we;
    logic [4:0]     ld_addr;
    logic [DW-1:0]  ld_data;
    logic           go;
    logic           busy;
    logic           fin;
    logic           err;
    logic [3:0]     rd_addr;
    logic [DW-1:0]  rd_data;
`ifdef FEEDER_CHECKSUM_EN
    logic [11:0]    chk_sum;
`endif

    matrix_feeder_if #(.DW(DW)) mm_if ();

    matrix_feeder #(
        .N       (N),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .go      (go),
        .busy    (busy),
        .fin     (fin),
        .err     (err),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .mm      (mm_if)
`ifdef FEEDER_CHECKSUM_EN
        ,
        .chk_sum (chk_sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] op_m  [NOP];
    logic [DW-1:0] res_m [NRES];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int addr, input logic [DW-1:0] data);
        ld_we   = 1'b1;
        ld_addr = 5'(addr);
        ld_data = data;
        @(negedge clk);
        ld_we   = 1'b0;
        if (addr < NOP) op_m[addr] = data;
    endtask

    task automatic rd(input int addr, output logic [DW-1:0] data);
        rd_addr = 4'(addr);
        @(negedge clk);
        data = rd_data;
    endtask

    task automatic check_results();
        logic [DW-1:0] v;
        for (int i = 0; i < NRES; i++) begin
            rd(i, v);
            check_eq($sformatf("res[%0d]", i), 32'(v), 32'(res_m[i]));
        end
        rd(NRES + 3, v);
        check_eq("res_oob", 32'(v), 0);
    endtask

    // Expected product C = A*B truncated to DW bits, row-major.
    task automatic product(output logic [DW-1:0] c [NRES], output int sum);
        sum = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                int acc = 0;
                for (int k = 0; k < N; k++)
                    acc += int'(op_m[i*N+k]) * int'(op_m[NRES + k*N + j]);
                c[i*N+j] = DW'(acc & 255);
                sum += acc & 255;
            end
        end
    endtask

    // mode 0: multiplier answers with ndone bytes after dly idle cycles
    // mode 1: multiplier never answers
    // inject 1: rst while the 7th element streams; inject 2: ld/go mid-stream
    task automatic do_run(input int mode, input int ndone, input int inject,
                          input int dly);
        logic [DW-1:0] c [NRES];
        int sum;
        int st_cnt;
        int cyc;
        int fin_seen;
        product(c, sum);
        st_cnt   = 0;
        fin_seen = 0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        if (mm_if.st) st_cnt++;
        check_eq("busy_start", 32'(busy), 1);
        for (int k = 0; k < NOP; k++) begin
            @(negedge clk);
            if (mm_if.st) st_cnt++;
            if (inject == 2 && k == 4) begin
                ld_we = 1'b0;
                go    = 1'b0;
            end
            check_eq($sformatf("stream[%0d]", k), 32'(mm_if.data_in), 32'(op_m[k]));
            if (inject == 1 && k == 6) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_eq("rst_st", 32'(mm_if.st), 0);
                check_eq("rst_data", 32'(mm_if.data_in), 0);
                check_eq("rst_busy", 32'(busy), 0);
                check_eq("rst_err", 32'(err), 0);
                return;
            end
            if (inject == 2 && k == 3) begin
                ld_we   = 1'b1;
                ld_addr = 5'd0;
                ld_data = 8'hFF;
                go      = 1'b1;
            end
        end
        @(negedge clk);
        if (mm_if.st) st_cnt++;
        check_eq("wait_data", 32'(mm_if.data_in), 0);
        check_eq("wait_busy", 32'(busy), 1);
        if (mode == 1) begin
            cyc = 0;
            while (busy && cyc < 2 * TIMEOUT) begin
                @(negedge clk);
                if (fin) fin_seen++;
                cyc++;
            end
            check_eq("timeout_cycles", 32'(cyc), 32'(TIMEOUT));
            check_eq("timeout_err", 32'(err), 1);
            check_eq("timeout_fin", 32'(fin_seen), 0);
        end else begin
            repeat (dly) @(negedge clk);
            for (int j = 0; j < ndone; j++) begin
                mm_if.done    = 1'b1;
                mm_if.dataout = c[j];
                @(negedge clk);
                if (fin && j < ndone - 1) fin_seen++;
                res_m[j] = c[j];
            end
            mm_if.done    = 1'b0;
            mm_if.dataout = '0;
            if (ndone == NRES) begin
                check_eq("fin_pulse", 32'(fin), 1);
                check_eq("fin_early", 32'(fin_seen), 0);
`ifdef FEEDER_CHECKSUM_EN
                check_eq("chk_sum", 32'(chk_sum), 32'(sum));
`endif
                @(negedge clk);
                check_eq("fin_one_cycle", 32'(fin), 0);
                check_eq("done_busy", 32'(busy), 0);
                check_eq("done_err", 32'(err), 0);
            end else begin
                @(negedge clk);
                check_eq("short_err", 32'(err), 1);
                check_eq("short_busy", 32'(busy), 0);
                check_eq("short_fin", 32'(fin), 0);
            end
        end
        check_eq("st_pulses", 32'(st_cnt), 1);
    endtask

    task automatic load_scenario1();
        for (int i = 0; i < NRES; i++) load(i, DW'(i + 1));
        for (int i = 0; i < NRES; i++) load(NRES + i, (i % (N + 1) == 0) ? 8'd1 : 8'd0);
    endtask

    task automatic load_random();
        for (int i = 0; i < NOP; i++) load(i, DW'($urandom_range(0, 255)));
        load($urandom_range(NOP, 31), DW'($urandom_range(0, 255)));
    endtask

    initial begin
        logic [DW-1:0] v;
        rst           = 1'b1;
        go            = 1'b0;
        ld_we         = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;
        rd_addr       = '0;
        mm_if.done    = 1'b0;
        mm_if.dataout = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy0", 32'(busy), 0);
        check_eq("rst_fin0", 32'(fin), 0);
        check_eq("rst_err0", 32'(err), 0);
        check_eq("rst_mm_st0", 32'(mm_if.st), 0);
        check_eq("rst_mm_data0", 32'(mm_if.data_in), 0);
        check_eq("rst_rd_data0", 32'(rd_data), 0);
        rst = 1'b0;
        @(negedge clk);

        load_scenario1();
        do_run(0, NRES, 0, 2);
        rd(4, v);
        check_eq("s1_rd4", 32'(v), 5);
        rd(8, v);
        check_eq("s1_rd8", 32'(v), 9);
        check_results();

        do_run(1, 0, 0, 0);
        check_results();

        load_random();
        do_run(0, 4, 0, 1);
        check_results();

        load_scenario1();
        do_run(0, NRES, 1, 0);
        do_run(0, NRES, 0, 0);
        check_results();

        do_run(0, NRES, 2, 0);
        check_eq("ignored_ld", 32'(op_m[0]), 1);
        do_run(0, NRES, 0, 3);
        check_results();

        for (int r = 0; r < 4; r++) begin
            load_random();
            do_run(0, NRES, 0, $urandom_range(0, 5));
            check_results();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
